// File: rtl/fnd_pkg.sv
// Shared constants for the 7-segment (FND) display blocks.
// Segment patterns are active-low, bit order g..a (bit 6 = g, bit 0 = a).
package fnd_pkg;

  // Enough BCD digits to hold any binary input up to 27 bits (2^27-1 = 134,217,727)
  localparam int BCD_MAX_DIGITS = 9;

  // Glyphs for nibble values 0-9, A, b, C, d, E, F
  localparam logic [6:0] GLYPH_TABLE [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Only segment g lit: shown on every digit when the value does not fit
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // All segments dark: used for blanked leading zeros
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    return GLYPH_TABLE[nib];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per cycle.
// done/bcd/ovf are combinational and describe the value produced by the final
// shift, so the consumer can capture it on the same edge that busy drops.
module bin2bcd_seq import fnd_pkg::*; #(
  parameter int DATA_W = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BCD_W = 4 * BCD_MAX_DIGITS;
  localparam int CW    = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] sreg;
  logic [BCD_W-1:0]  acc;
  logic [BCD_W-1:0]  adj;
  logic [BCD_W-1:0]  next_acc;
  logic [CW-1:0]     cnt;

  // Add-3 correction on every BCD digit >= 5, then shift in the next binary bit
  always_comb begin
    adj = acc;
    for (int d = 0; d < BCD_MAX_DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5)
        adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    end
    next_acc = {adj[BCD_W-2:0], sreg[DATA_W-1]};
  end

  assign done = busy && (cnt == CW'(1));
  assign bcd  = next_acc[4*DIGITS-1:0];
  assign ovf  = (next_acc >> (4*DIGITS)) != '0;

  // Load on start, then step once per cycle for DATA_W cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start && !busy) begin
      sreg <= bin;
      acc  <= '0;
      cnt  <= CW'(DATA_W);
      busy <= 1'b1;
    end else if (busy) begin
      sreg <= {sreg[DATA_W-2:0], 1'b0};
      acc  <= next_acc;
      cnt  <= cnt - CW'(1);
      if (cnt == CW'(1))
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed 7-segment display scanner with hex/decimal input, leading-zero
// blanking, overflow dashes and whole-display blink.
module fnd_scan_ctrl import fnd_pkg::*; #(
  parameter int DIGITS      = 4,
  parameter int DATA_W      = 14,
  parameter int SCAN_DIV    = 100_000,
  parameter int BLINK_SCANS = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data,
  input  logic              mode_hex,
  input  logic [DIGITS-1:0] dp,
  input  logic              blank_lz,
  input  logic              blink_en,
  output logic              busy,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] seg_comm
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int BW = $clog2(BLINK_SCANS + 1);

  logic                  accept;
  logic                  conv_done;
  logic                  conv_ovf;
  logic [4*DIGITS-1:0]   conv_bcd;
  logic [31:0]           hex_ext;
  logic                  hex_ovf;

  logic [4*DIGITS-1:0]   disp_val;
  logic                  disp_ovf;

  logic [PW-1:0]         presc;
  logic                  tick;
  logic [IW-1:0]         index;
  logic                  started;
  logic [BW-1:0]         blink_cnt;
  logic                  phase_on;

  logic [3:0]            cur_nib;
  logic                  blank_now;
  logic [6:0]            glyph_now;
  logic [DIGITS-1:0]     comm_now;

  assign accept  = data_valid && !busy;
  assign hex_ext = {{(32-DATA_W){1'b0}}, data};
  assign hex_ovf = (hex_ext >> (4*DIGITS)) != 32'd0;

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (accept && !mode_hex),
    .bin   (data),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  // Display register: hex loads directly, decimal loads when conversion ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_val <= '0;
      disp_ovf <= 1'b0;
    end else if (accept && mode_hex) begin
      disp_val <= hex_ext[4*DIGITS-1:0];
      disp_ovf <= hex_ovf;
    end else if (conv_done) begin
      disp_val <= conv_bcd;
      disp_ovf <= conv_ovf;
    end
  end

  assign tick = (presc == PW'(SCAN_DIV - 1));

  // Scan prescaler, digit index and blink phase; first tick only enables output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      index     <= '0;
      started   <= 1'b0;
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        if (!started)
          started <= 1'b1;
        else if (index == IW'(DIGITS - 1))
          index <= '0;
        else
          index <= index + IW'(1);
        if (blink_cnt == BW'(BLINK_SCANS - 1)) begin
          blink_cnt <= '0;
          phase_on  <= ~phase_on;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

  // Select the glyph and digit strobe for the current index
  always_comb begin
    cur_nib   = disp_val[4*int'(index) +: 4];
    blank_now = blank_lz && (index != '0) &&
                ((disp_val >> (4*int'(index))) == '0);
    if (disp_ovf)
      glyph_now = SEG_DASH;
    else if (blank_now)
      glyph_now = SEG_BLANK;
    else
      glyph_now = glyph(cur_nib);
    if (blink_en && !phase_on)
      comm_now = '1;
    else
      comm_now = ~(DIGITS'(1) << index);
  end

  // Registered outputs; dark until the first scan tick after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg      <= 8'hFF;
      seg_comm <= '1;
    end else if (started) begin
      seg      <= {~dp[index], glyph_now};
      seg_comm <= comm_now;
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed self-checking bench for fnd_scan_ctrl (4 digits, fast scan).
module tb_fnd_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        data_valid;
  logic [13:0] data;
  logic        mode_hex;
  logic [3:0]  dp;
  logic        blank_lz;
  logic        blink_en;
  logic        busy;
  logic [7:0]  seg;
  logic [3:0]  seg_comm;

  int checks = 0;
  int errors = 0;

  fnd_scan_ctrl #(
    .DIGITS      (4),
    .DATA_W      (14),
    .SCAN_DIV    (4),
    .BLINK_SCANS (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_valid (data_valid),
    .data       (data),
    .mode_hex   (mode_hex),
    .dp         (dp),
    .blank_lz   (blank_lz),
    .blink_en   (blink_en),
    .busy       (busy),
    .seg        (seg),
    .seg_comm   (seg_comm)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One-cycle data_valid strobe, returns at the negedge after acceptance
  task automatic applyStimulus(input logic [13:0] value, input logic hex);
    @(negedge clk);
    data       = value;
    mode_hex   = hex;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  // Wait (bounded) until digit idx is strobed, then return its segments
  task automatic waitDigit(input string tag, input int idx, output logic [7:0] s);
    logic [3:0] want;
    int n;
    want = ~(4'b0001 << idx);
    n = 0;
    while (seg_comm !== want && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (seg_comm !== want)
      checkOutput({tag, "_timeout"}, {28'd0, seg_comm}, {28'd0, want});
    s = seg;
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy)
      checkOutput({tag, "_busy_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  // Check all four digits against an expected segment list (digit 0 first)
  task automatic checkDisplay(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] s;
    logic [7:0] exp_seg [4];
    exp_seg = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      waitDigit(tag, i, s);
      checkOutput($sformatf("%s_d%0d", tag, i), {24'd0, s}, {24'd0, exp_seg[i]});
    end
  endtask

  logic [7:0] s;
  logic [7:0] hold_exp [4];
  int         n;
  int         found;

  initial begin
    rst        = 1'b1;
    data_valid = 1'b0;
    data       = '0;
    mode_hex   = 1'b0;
    dp         = 4'b0000;
    blank_lz   = 1'b0;
    blink_en   = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_seg", {24'd0, seg}, 32'h0000_00FF);
    checkOutput("rst_comm", {28'd0, seg_comm}, 32'h0000_000F);
    rst = 1'b0;

    // Decimal 1234: busy for exactly 14 cycles, then 4,3,2,1
    applyStimulus(14'd1234, 1'b0);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput("dec_busy_cycles", n, 32'd14);
    checkDisplay("dec1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);

    // Leading-zero blanking on 7
    blank_lz = 1'b1;
    applyStimulus(14'd7, 1'b0);
    waitIdle("blank7");
    checkDisplay("blank7", 8'hF8, 8'hFF, 8'hFF, 8'hFF);

    // Decimal overflow shows dashes everywhere, blanking ignored
    applyStimulus(14'd12000, 1'b0);
    waitIdle("ovf");
    checkDisplay("ovf12000", 8'hBF, 8'hBF, 8'hBF, 8'hBF);
    blank_lz = 1'b0;

    // Hex 0x3A5F: no busy, display F,5,A,3
    applyStimulus(14'h3A5F, 1'b1);
    checkOutput("hex_busy", {31'd0, busy}, 32'd0);
    checkDisplay("hex3A5F", 8'h8E, 8'h92, 8'h88, 8'hB0);

    // Decimal 1234 with a second strobe (99) while busy; old value held meanwhile
    hold_exp = '{8'h8E, 8'h92, 8'h88, 8'hB0};
    applyStimulus(14'd1234, 1'b0);
    checkOutput("ign_busy_start", {31'd0, busy}, 32'd1);
    repeat (2) @(negedge clk);
    data       = 14'd99;
    mode_hex   = 1'b0;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (3) @(negedge clk);
    found = -1;
    for (int i = 0; i < 4; i++)
      if (seg_comm == ~(4'b0001 << i)) found = i;
    checkOutput("hold_busy", {31'd0, busy}, 32'd1);
    if (found < 0)
      checkOutput("hold_comm", {28'd0, seg_comm}, 32'h0000_000E);
    else
      checkOutput("hold_seg", {24'd0, seg}, {24'd0, hold_exp[found]});
    waitIdle("ign");
    dp = 4'b0100;
    checkDisplay("ign1234", 8'h99, 8'hB0, 8'h24, 8'hF9);
    dp = 4'b0000;

    // Blink: two ticks dark, two ticks scanning
    blink_en = 1'b1;
    n = 0;
    while (seg_comm !== 4'hF && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (seg_comm === 4'hF && n < 100) begin @(negedge clk); n++; end
    if (seg_comm === 4'hF)
      checkOutput("blink_timeout", {28'd0, seg_comm}, 32'h0000_000E);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("blink_off_k%0d", k), {31'd0, (seg_comm == 4'hF)},
                  {31'd0, ((k % 4) >= 2)});
      repeat (4) @(negedge clk);
    end
    blink_en = 1'b0;

    // Reset in the middle of a conversion
    applyStimulus(14'd1234, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_seg", {24'd0, seg}, 32'h0000_00FF);
    checkOutput("midrst_comm", {28'd0, seg_comm}, 32'h0000_000F);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    waitDigit("midrst", 0, s);
    checkOutput("midrst_d0", {24'd0, s}, 32'h0000_00C0);
    checkOutput("midrst_busy_after", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fnd_scan_ctrl.md
FND_SCAN_CTRL -- requirements
Module: fnd_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 4: number of 7-segment digits driven, range 2..8.
REQ-002 Parameter DATA_W, default 14: binary input width, range 4..27.
REQ-003 Parameter SCAN_DIV, default 100_000: clk cycles per digit-scan tick, minimum 2.
REQ-004 Parameter BLINK_SCANS, default 128: scan ticks per blink half-period.
REQ-005 clk  input  1  system clock, rising-edge active.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 data_valid  input  1  one-cycle strobe qualifying data.
REQ-008 data  input  DATA_W  unsigned value to display.
REQ-009 mode_hex  input  1  sampled with data_valid: 1 = hexadecimal, 0 = decimal.
REQ-010 dp  input  DIGITS  per-digit decimal point enable, bit 0 = rightmost digit, used live.
REQ-011 blank_lz  input  1  leading-zero blanking enable, used live.
REQ-012 blink_en  input  1  whole-display blink enable, used live.
REQ-013 busy  output  1  high while a decimal conversion is in progress.
REQ-014 seg  output  8  active-low segments; bit 7 = dp, bits 6..0 = g..a.
REQ-015 seg_comm  output  DIGITS  active-low one-hot digit select.

Function
REQ-016 data_valid with busy=0 shall latch data and mode_hex in that cycle; data_valid with busy=1 shall be ignored.
REQ-017 Hex mode: the display register shall update on the cycle after acceptance, digit i = data[4i+3:4i], with zero-extension; busy stays 0.
REQ-018 Decimal mode: sequential shift-add-3 conversion, one bit per cycle; busy high for exactly DATA_W cycles starting the cycle after acceptance; the display register shall update atomically on the cycle busy falls.
REQ-019 During conversion, the previously displayed value shall remain on the outputs unchanged.
REQ-020 Decimal overflow (value > 10^DIGITS-1), or hex value with nonzero bits above 4*DIGITS: every digit shall show "-" (segments 0111111, g only lit), with dp still applied.
REQ-021 Scan tick: a prescaler shall count 0..SCAN_DIV-1 and pulse for one cycle at the wrap; the digit index shall advance 0..DIGITS-1 and wrap to 0 on each tick.
REQ-022 seg_comm shall drive bit [index] low; all other bits high.
REQ-023 seg[6:0] shall be the glyph for the nibble selected by index: 0-9, A, b, C, d, E, F.
REQ-024 seg[7] shall equal ~dp[index].
REQ-025 Blanking: with blank_lz=1, digit i>0 shall be blank (seg[6:0]=all 1) when digits i..DIGITS-1 are all zero; digit 0 shall never be blanked; blanking is not applied in the overflow display.
REQ-026 Blink: a counter of scan ticks shall toggle a phase bit every BLINK_SCANS ticks; with blink_en=1 and phase=off, seg_comm shall be all 1s; blink_en=0 forces the display on without resetting the phase.
REQ-027 seg and seg_comm shall be registered outputs, updating one cycle after an index or content change.

Reset
REQ-028 On rst: busy=0, seg=8'hFF, seg_comm all 1s, index=0, prescaler=0, blink phase=on, display register=0, conversion state idle.
REQ-029 rst asserted mid-conversion shall abort the conversion, and the display register shall remain 0.
REQ-030 After rst is released, the first digit shall be enabled at the first scan tick.

Structure
REQ-031 The glyph table constants, the dash glyph, and the blank glyph shall reside in the shared package fnd_pkg.
REQ-032 The binary-to-BCD converter shall be a sub-module named bin2bcd_seq with ports start, bin, busy, done, bcd, and ovf.

Verification
REQ-033 Use DIGITS=4, SCAN_DIV=4, decimal; data=1234 -> busy=1 for 14 cycles, then the scan shows digits 4,3,2,1 with seg 8'h99,8'hB0,8'hA4,8'hF9.
REQ-034 Decimal, data=7, blank_lz=1 -> digits 3..1 show seg 8'hFF with their common lines still cycling, and digit 0 shows 8'hF8.
REQ-035 Decimal, data=12000 -> all four digits show 8'hBF; in hex mode, data=0x3A5F -> digits F,5,A,3 appear immediately with busy=0.
REQ-036 Second data_valid (data=99) during a busy conversion -> ignored; the display shows only the first value.
REQ-037 blink_en=1, BLINK_SCANS=2 -> seg_comm is all 1s for 2 ticks, then scanning resumes for 2 ticks, repeating.
REQ-038 rst pulse at conversion cycle 5 -> seg=8'hFF, seg_comm=4'hF, and busy=0 immediately; after release, digit 0 shows "0" (8'hC0).
